// File: rtl/idex_stage.sv
// ID/EX pipeline register for the pipelined MIPS core. It detects load-use
// hazards, handles EX flush and hold, and keeps a saturating stall counter.
module idex_stage #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned IMM_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs,
    input  logic [ADDR_WIDTH-1:0] id_rt,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic [IMM_WIDTH-1:0]  id_imm,
    input  logic [8:0]            id_ctrl,
    input  logic [D_WIDTH-1:0]    rdata1,
    input  logic [D_WIDTH-1:0]    rdata2,
    input  logic                  ex_flush,
    input  logic                  ex_hold,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [D_WIDTH-1:0]    ex_a,
    output logic [D_WIDTH-1:0]    ex_b,
    output logic [D_WIDTH-1:0]    ex_imm,
    output logic [ADDR_WIDTH-1:0] ex_rs,
    output logic [ADDR_WIDTH-1:0] ex_rt,
    output logic [ADDR_WIDTH-1:0] ex_wreg,
    output logic [8:0]            ex_ctrl,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam int unsigned CTRL_WIDTH  = 9;
    localparam int unsigned MEMREAD_BIT = 7;
    localparam int unsigned REGDST_BIT  = 3;
    localparam int unsigned EXT_WIDTH   = D_WIDTH - IMM_WIDTH;

    logic               load_use_c;
    logic [D_WIDTH-1:0] imm_ext_c;

    // Hazard detection against the load sitting in EX; register 0 is never a hazard.
    always_comb begin
        load_use_c = ex_valid & ex_ctrl[MEMREAD_BIT] & (ex_rt != '0) & id_valid &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
        imm_ext_c  = {{EXT_WIDTH{id_imm[IMM_WIDTH-1]}}, id_imm};
        stall_out  = rst_n & ~ex_flush & (ex_hold | load_use_c);
    end

    // Pipeline register: flush beats hold, hold beats the load-use bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || ex_flush || (!ex_hold && load_use_c)) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_wreg  <= '0;
            ex_ctrl  <= '0;
        end else if (!ex_hold) begin
            ex_valid <= id_valid;
            ex_a     <= rdata1;
            ex_b     <= rdata2;
            ex_imm   <= imm_ext_c;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_wreg  <= id_ctrl[REGDST_BIT] ? id_rd : id_rt;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_WIDTH'(0);
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_out && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
